// File: rtl/arf_rat_pkg.sv
// Shared definitions for the architectural register file / rename table:
// sizing constants, id and data types, and the per-register rename entry.
package arf_rat_pkg;

    localparam int ARF_N_ENTRIES  = 32;
    localparam int ROB_N_ENTRIES  = 16;
    localparam int REG_DATA_WIDTH = 32;

    localparam int ARF_ID_WIDTH = $clog2(ARF_N_ENTRIES);
    localparam int ROB_ID_WIDTH = $clog2(ROB_N_ENTRIES);

    typedef logic [ARF_ID_WIDTH-1:0]   arf_id_t;
    typedef logic [ROB_ID_WIDTH-1:0]   rob_id_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

    typedef struct packed {
        logic    renamed;
        rob_id_t rob_id;
    } rat_entry_t;

endpackage

// File: rtl/arf_rat_if.sv
// Dispatch, lookup, retire and flush signals between the pipeline and the ARF/RAT.
interface arf_rat_if;
    import arf_rat_pkg::*;

    logic      dispatch_fire;
    logic      dispatch_dst_valid;
    arf_id_t   dispatch_dst_arf_id;
    rob_id_t   dispatch_rob_id;

    arf_id_t   src1_arf_id;
    arf_id_t   src2_arf_id;
    logic      src1_renamed;
    logic      src2_renamed;
    rob_id_t   src1_rob_id;
    rob_id_t   src2_rob_id;
    reg_data_t src1_arf_data;
    reg_data_t src2_arf_data;

    logic      retire;
    rob_id_t   retire_rob_id;
    arf_id_t   retire_arf_id;
    reg_data_t retire_reg_data;

    logic      flush;

    modport master (
        output dispatch_fire, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_rob_id,
        output src1_arf_id, src2_arf_id,
        input  src1_renamed, src2_renamed, src1_rob_id, src2_rob_id,
        input  src1_arf_data, src2_arf_data,
        output retire, retire_rob_id, retire_arf_id, retire_reg_data,
        output flush
    );

    modport slave (
        input  dispatch_fire, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_rob_id,
        input  src1_arf_id, src2_arf_id,
        output src1_renamed, src2_renamed, src1_rob_id, src2_rob_id,
        output src1_arf_data, src2_arf_data,
        input  retire, retire_rob_id, retire_arf_id, retire_reg_data,
        input  flush
    );

endinterface

// File: rtl/arf_rat_entry.sv
// One architectural register: committed data word, renamed bit and ROB tag,
// with the dispatch / retire / flush next-state rules for that register.
module arf_rat_entry #(
    parameter int ENTRY_ID = 1,
    parameter int ARF_ID_W = 5,
    parameter int ROB_ID_W = 4,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst_aL,
    input  logic                dispatch_fire,
    input  logic                dispatch_dst_valid,
    input  logic [ARF_ID_W-1:0] dispatch_dst_arf_id,
    input  logic [ROB_ID_W-1:0] dispatch_rob_id,
    input  logic                retire,
    input  logic [ROB_ID_W-1:0] retire_rob_id,
    input  logic [ARF_ID_W-1:0] retire_arf_id,
    input  logic [DATA_W-1:0]   retire_reg_data,
    input  logic                flush,
    output logic [ROB_ID_W:0]   rat_o,
    output logic [DATA_W-1:0]   data_o
);

    localparam logic [ARF_ID_W-1:0] MY_ID = ARF_ID_W'(ENTRY_ID);

    logic [DATA_W-1:0]   data_q,    data_d;
    logic                renamed_q, renamed_d;
    logic [ROB_ID_W-1:0] tag_q,     tag_d;

    logic retire_hit;
    logic rename_hit;

    always_comb begin
        retire_hit = retire && (retire_arf_id == MY_ID);
        rename_hit = dispatch_fire && dispatch_dst_valid && (dispatch_dst_arf_id == MY_ID);

        data_d    = data_q;
        renamed_d = renamed_q;
        tag_d     = tag_q;

        if (retire_hit) begin
            data_d = retire_reg_data;
            // Only the exact producer clears the mapping; a younger rename survives.
            if (tag_q == retire_rob_id) begin
                renamed_d = 1'b0;
            end
        end

        // A new rename overrides a same-cycle retire clear; flush overrides both.
        if (rename_hit) begin
            renamed_d = 1'b1;
            tag_d     = dispatch_rob_id;
        end

        if (flush) begin
            renamed_d = 1'b0;
            tag_d     = tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            data_q    <= '0;
            renamed_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            renamed_q <= renamed_d;
        end
        // NOTE: the tag is deliberately not reset; it is meaningless while renamed is 0.
        tag_q <= tag_d;
    end

    assign rat_o  = {renamed_q, tag_q};
    assign data_o = data_q;

endmodule

// File: rtl/arf_rat.sv
// Architectural register file plus register alias table: one entry per
// architectural register (x0 hard-wired to zero) and two combinational source lookups.
module arf_rat
    import arf_rat_pkg::rat_entry_t;
#(
    parameter int ARF_N_ENTRIES  = arf_rat_pkg::ARF_N_ENTRIES,
    parameter int ROB_N_ENTRIES  = arf_rat_pkg::ROB_N_ENTRIES,
    parameter int REG_DATA_WIDTH = arf_rat_pkg::REG_DATA_WIDTH
) (
    input  logic       clk,
    input  logic       rst_aL,
    arf_rat_if.slave   bus
);

    localparam int ARF_ID_W = $clog2(ARF_N_ENTRIES);
    localparam int ROB_ID_W = $clog2(ROB_N_ENTRIES);

    rat_entry_t                rat_arr  [ARF_N_ENTRIES];
    logic [REG_DATA_WIDTH-1:0] data_arr [ARF_N_ENTRIES];

    assign rat_arr[0]  = '0;
    assign data_arr[0] = '0;

    for (genvar i = 1; i < ARF_N_ENTRIES; i++) begin : g_entry
        arf_rat_entry #(
            .ENTRY_ID (i),
            .ARF_ID_W (ARF_ID_W),
            .ROB_ID_W (ROB_ID_W),
            .DATA_W   (REG_DATA_WIDTH)
        ) u_entry (
            .clk                 (clk),
            .rst_aL              (rst_aL),
            .dispatch_fire       (bus.dispatch_fire),
            .dispatch_dst_valid  (bus.dispatch_dst_valid),
            .dispatch_dst_arf_id (bus.dispatch_dst_arf_id),
            .dispatch_rob_id     (bus.dispatch_rob_id),
            .retire              (bus.retire),
            .retire_rob_id       (bus.retire_rob_id),
            .retire_arf_id       (bus.retire_arf_id),
            .retire_reg_data     (bus.retire_reg_data),
            .flush               (bus.flush),
            .rat_o               (rat_arr[i]),
            .data_o              (data_arr[i])
        );
    end

    // Lookups read registered state only, so same-cycle updates are not bypassed.
    always_comb begin
        bus.src1_renamed  = 1'b0;
        bus.src1_rob_id   = '0;
        bus.src1_arf_data = '0;
        bus.src2_renamed  = 1'b0;
        bus.src2_rob_id   = '0;
        bus.src2_arf_data = '0;

        if (bus.src1_arf_id != '0) begin
            bus.src1_renamed  = rat_arr[bus.src1_arf_id].renamed;
            bus.src1_rob_id   = rat_arr[bus.src1_arf_id].rob_id;
            bus.src1_arf_data = data_arr[bus.src1_arf_id];
        end

        if (bus.src2_arf_id != '0) begin
            bus.src2_renamed  = rat_arr[bus.src2_arf_id].renamed;
            bus.src2_rob_id   = rat_arr[bus.src2_arf_id].rob_id;
            bus.src2_arf_data = data_arr[bus.src2_arf_id];
        end
    end

endmodule

// File: tb/tb_arf_rat.sv
// Directed bench for arf_rat: reset, rename/retire, tag match, flush and x0 behaviour.
module tb_arf_rat;
    import arf_rat_pkg::*;

    logic clk;
    logic rst_aL;
    int   tests;
    int   fails;

    arf_rat_if bus ();

    arf_rat u_dut (
        .clk    (clk),
        .rst_aL (rst_aL),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.dispatch_fire       = 1'b0;
        bus.dispatch_dst_valid  = 1'b0;
        bus.dispatch_dst_arf_id = '0;
        bus.dispatch_rob_id     = '0;
        bus.retire              = 1'b0;
        bus.retire_rob_id       = '0;
        bus.retire_arf_id       = '0;
        bus.retire_reg_data     = '0;
        bus.flush               = 1'b0;
    endtask

    task automatic set_dispatch(input int dst, input int rob);
        bus.dispatch_fire       = 1'b1;
        bus.dispatch_dst_valid  = 1'b1;
        bus.dispatch_dst_arf_id = arf_id_t'(dst);
        bus.dispatch_rob_id     = rob_id_t'(rob);
    endtask

    task automatic set_retire(input int dst, input int rob, input logic [31:0] data);
        bus.retire          = 1'b1;
        bus.retire_arf_id   = arf_id_t'(dst);
        bus.retire_rob_id   = rob_id_t'(rob);
        bus.retire_reg_data = data;
    endtask

    // Apply driven inputs at the next edge, then return to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic look(input int s1, input int s2);
        bus.src1_arf_id = arf_id_t'(s1);
        bus.src2_arf_id = arf_id_t'(s2);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle();
        look(0, 0);

        // Reset with every other control active: reset must win.
        rst_aL = 1'b0;
        set_dispatch(6, 1);
        set_retire(6, 1, 32'h0000_0055);
        bus.flush = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_aL = 1'b1;
        idle();

        look(5, 6);
        check("rst_x5_renamed", 32'(bus.src1_renamed), 32'd0);
        check("rst_x5_data",    bus.src1_arf_data,     32'd0);
        check("rst_x6_renamed", 32'(bus.src2_renamed), 32'd0);
        check("rst_x6_data",    bus.src2_arf_data,     32'd0);

        // Basic rename then retire.
        set_dispatch(5, 3);
        look(5, 0);
        check("no_bypass_renamed", 32'(bus.src1_renamed), 32'd0);
        tick();
        look(5, 0);
        check("x5_renamed",  32'(bus.src1_renamed), 32'd1);
        check("x5_rob_id",   32'(bus.src1_rob_id),  32'd3);
        set_retire(5, 3, 32'hDEAD_BEEF);
        tick();
        look(5, 0);
        check("x5_retired_renamed", 32'(bus.src1_renamed), 32'd0);
        check("x5_retired_data",    bus.src1_arf_data,     32'hDEAD_BEEF);

        // Fire without dst_valid, and dst_valid without fire: no rename.
        bus.dispatch_fire = 1'b1; bus.dispatch_dst_arf_id = 5'd10; bus.dispatch_rob_id = 4'd2;
        tick();
        bus.dispatch_dst_valid = 1'b1; bus.dispatch_dst_arf_id = 5'd11; bus.dispatch_rob_id = 4'd2;
        tick();
        look(10, 11);
        check("no_dst_valid_renamed", 32'(bus.src1_renamed), 32'd0);
        check("no_fire_renamed",      32'(bus.src2_renamed), 32'd0);

        // Older retire must not clear a younger mapping.
        set_dispatch(7, 2);
        tick();
        set_dispatch(7, 4);
        tick();
        set_retire(7, 2, 32'h0000_0011);
        tick();
        look(0, 7);
        check("x7_young_renamed", 32'(bus.src2_renamed), 32'd1);
        check("x7_young_rob_id",  32'(bus.src2_rob_id),  32'd4);
        check("x7_old_data",      bus.src2_arf_data,     32'h0000_0011);
        set_retire(7, 4, 32'h0000_0044);
        tick();
        look(0, 7);
        check("x7_final_renamed", 32'(bus.src2_renamed), 32'd0);
        check("x7_final_data",    bus.src2_arf_data,     32'h0000_0044);

        // Same-cycle rename and retire-clear on one register.
        set_dispatch(9, 1);
        tick();
        set_dispatch(9, 6);
        set_retire(9, 1, 32'h0000_0022);
        tick();
        look(9, 0);
        check("x9_renamed", 32'(bus.src1_renamed), 32'd1);
        check("x9_rob_id",  32'(bus.src1_rob_id),  32'd6);
        check("x9_data",    bus.src1_arf_data,     32'h0000_0022);

        // Highest tag value is stored and matched unmodified.
        set_dispatch(31, 15);
        tick();
        look(31, 0);
        check("x31_rob_id", 32'(bus.src1_rob_id), 32'd15);
        set_retire(31, 15, 32'hA5A5_0031);
        tick();
        look(31, 0);
        check("x31_renamed", 32'(bus.src1_renamed), 32'd0);
        check("x31_data",    bus.src1_arf_data,     32'hA5A5_0031);

        // Rename x1..x4, then flush with a same-cycle dispatch and retire.
        for (int r = 1; r <= 4; r++) begin
            set_dispatch(r, r + 7);
            tick();
        end
        look(3, 4);
        check("x3_pre_flush_renamed", 32'(bus.src1_renamed), 32'd1);
        check("x4_pre_flush_rob_id",  32'(bus.src2_rob_id),  32'd11);
        set_dispatch(8, 5);
        set_retire(2, 9, 32'h0000_0033);
        bus.flush = 1'b1;
        tick();
        for (int r = 1; r <= 4; r++) begin
            look(r, 0);
            check($sformatf("flush_x%0d_renamed", r), 32'(bus.src1_renamed), 32'd0);
        end
        look(8, 9);
        check("flush_x8_renamed", 32'(bus.src1_renamed), 32'd0);
        check("flush_x9_renamed", 32'(bus.src2_renamed), 32'd0);
        look(2, 5);
        check("flush_x2_data", bus.src1_arf_data, 32'h0000_0033);
        check("flush_x5_data", bus.src2_arf_data, 32'hDEAD_BEEF);

        // x0 ignores both rename and write.
        set_dispatch(0, 7);
        set_retire(0, 7, 32'h0000_00FF);
        tick();
        look(0, 0);
        check("x0_src1_renamed", 32'(bus.src1_renamed), 32'd0);
        check("x0_src1_data",    bus.src1_arf_data,     32'd0);
        check("x0_src2_renamed", 32'(bus.src2_renamed), 32'd0);
        check("x0_src2_data",    bus.src2_arf_data,     32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arf_rat.md
ARF_RAT -- requirements
Module: arf_rat

Interface
REQ-001 SHALL take parameter ARF_N_ENTRIES, default 32: number of architectural registers; entry 0 is x0.
REQ-002 SHALL take parameter ROB_N_ENTRIES, default 16: ROB depth; rob id width = clog2(ROB_N_ENTRIES).
REQ-003 SHALL take parameter REG_DATA_WIDTH, default 32: register data width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_aL  input  1  reset, synchronous, active-low.
REQ-006 dispatch_fire  input  1  dispatch handshake completed this cycle (ififo valid and ROB ready).
REQ-007 dispatch_dst_valid  input  1  dispatched instruction writes a destination.
REQ-008 dispatch_dst_arf_id  input  arf_id_t  destination architectural register.
REQ-009 dispatch_rob_id  input  rob_id_t  ROB id allocated to the dispatched instruction.
REQ-010 src1_arf_id / src2_arf_id  input  arf_id_t  source lookups for the instruction being dispatched.
REQ-011 src1_renamed / src2_renamed  output  1  source is pending in the ROB.
REQ-012 src1_rob_id / src2_rob_id  output  rob_id_t  producing ROB id; valid only when renamed.
REQ-013 src1_arf_data / src2_arf_data  output  reg_data_t  committed ARF value; valid only when not renamed.
REQ-014 retire  input  1  ROB head commits this cycle.
REQ-015 retire_rob_id  input  rob_id_t  ROB id of the retiring entry.
REQ-016 retire_arf_id  input  arf_id_t  destination of the retiring entry.
REQ-017 retire_reg_data  input  reg_data_t  result of the retiring entry.
REQ-018 flush  input  1  pipeline flush on mispredict; discards all speculative mappings.

Function
REQ-019 SHALL hold, per architectural register, a committed data word, a renamed bit and a rob id tag.
REQ-020 Source lookups SHALL be combinational from current state and SHALL NOT bypass same-cycle dispatch, retire or flush.
REQ-021 Lookup of x0 SHALL return renamed=0, data=0, regardless of state.
REQ-022 On retire with retire_arf_id != 0, the ARF data word SHALL take retire_reg_data at the next edge; the retire_arf_id==0 case SHALL write nothing.
REQ-023 On retire, the renamed bit of retire_arf_id SHALL clear only if its stored tag equals retire_rob_id; a younger mapping SHALL survive.
REQ-024 On dispatch_fire with dispatch_dst_valid and dispatch_dst_arf_id != 0, the entry SHALL set renamed=1 and tag=dispatch_rob_id at the next edge.
REQ-025 Simultaneous dispatch rename and retire-clear on the same register SHALL leave renamed=1 with the new tag; the ARF data write SHALL still occur.
REQ-026 flush SHALL clear every renamed bit at the next edge; same-cycle dispatch rename SHALL be ignored; same-cycle retire data write SHALL still occur.
REQ-027 Renames to different registers, a retire and lookups SHALL all proceed in one cycle with no stall; the block SHALL be always ready.
REQ-028 Tags SHALL be stored unmodified; ROB id wrap-around SHALL be handled solely by exact-match compare in REQ-023.

Reset
REQ-029 With rst_aL low at a rising edge, all data words SHALL become 0 and all renamed bits SHALL become 0; tags are don't-care.
REQ-030 Reset SHALL take priority over flush, retire and dispatch in the same cycle.
REQ-031 Outputs after reset SHALL be renamed=0, data=0 for every lookup.

Structure
REQ-032 arf_id_t, rob_id_t, reg_data_t and ARF_N_ENTRIES/ROB_N_ENTRIES/REG_DATA_WIDTH SHALL come from the shared global definitions package.
REQ-033 A rat_entry_t typedef (renamed, rob id tag) SHALL be added to the shared package.
REQ-034 One sub-module, arf_rat_entry (one register's data, renamed bit, tag and next-state logic), SHALL be instantiated ARF_N_ENTRIES-1 times; x0 SHALL be constant.

Verification
REQ-035 Reset, then lookup x5 -> renamed=0, data=0.
REQ-036 Dispatch dst x5 rob 3; next cycle lookup x5 -> renamed=1, rob_id=3; retire rob 3 x5 data 0xDEADBEEF -> next cycle renamed=0, data=0xDEADBEEF.
REQ-037 Dispatch x7 rob 2, then x7 rob 4; retire rob 2 x7 data 0x11 -> x7 renamed=1, rob_id=4, ARF data 0x11.
REQ-038 Same cycle dispatch x9 rob 6 and retire rob 1 x9 (old tag 1) data 0x22 -> renamed=1, rob_id=6, data 0x22.
REQ-039 Rename x1..x4, assert flush with dispatch x8 rob 5 and retire x2 data 0x33 -> all renamed=0, x8 unmapped, x2 data 0x33.
REQ-040 Dispatch and retire to x0 with data 0xFF -> x0 lookup renamed=0, data=0.
